// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the divided-clock ratio monitor.
// Imported by edge_detect and clk_ratio_monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        HIGH,
        LOW
    } mon_state_t;

    localparam int DEF_RATIO_WIDTH = 8;
    localparam int DEF_TIMEOUT     = 2 ** (DEF_RATIO_WIDTH + 1);

endpackage

// File: rtl/edge_detect.sv
// Two-flop sampler of a reference-synchronous clock with rise/fall pulses.
// No synchroniser: the observed signal is generated in the sampling domain.
module edge_detect
    import clk_mon_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic div_q;
    logic div_qq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q  <= 1'b0;
            div_qq <= 1'b0;
        end else begin
            div_q  <= sig;
            div_qq <= div_q;
        end
    end

    assign rise = div_q & ~div_qq;
    assign fall = ~div_q & div_qq;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Recovers period, high and low time of a divided clock in reference cycles
// and flags ratio mismatch, duty error and loss of clock.
module clk_ratio_monitor
    import clk_mon_pkg::*;
#(
    parameter int ratio_width = DEF_RATIO_WIDTH,
    parameter int TIMEOUT     = 2 ** (ratio_width + 1)
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_mon_en,
    input  logic                   i_div_clk,
    input  logic [ratio_width-1:0] i_exp_ratio,
    output logic [ratio_width-1:0] o_meas_ratio,
    output logic [ratio_width-1:0] o_high_cnt,
    output logic [ratio_width-1:0] o_low_cnt,
    output logic                   o_valid,
    output logic                   o_mismatch,
    output logic                   o_duty_err,
    output logic                   o_timeout
);

    localparam int CW = ratio_width + 1;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] TLAST = IW'(TIMEOUT - 1);

    mon_state_t state, state_nxt;
    logic [CW-1:0] per_cnt, high_cnt, low_cnt;
    logic [CW-1:0] per_nxt, high_nxt, low_nxt;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic rise, fall, pub, tmo_fire, tmo_clr;
    logic ovf, mis, duty;
    logic [CW-1:0] diff;

    logic st_valid, st_mis, st_duty;
    logic [ratio_width-1:0] st_meas, st_high, st_low;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

    edge_detect u_edge (
        .clk  (i_ref_clk),
        .rst  (i_rst),
        .sig  (i_div_clk),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        state_nxt = state;
        per_nxt   = per_cnt;
        high_nxt  = high_cnt;
        low_nxt   = low_cnt;
        idle_nxt  = idle_cnt;
        pub       = 1'b0;
        tmo_fire  = 1'b0;
        tmo_clr   = 1'b0;
        if (!i_mon_en) begin
            state_nxt = IDLE;
            per_nxt   = '0;
            high_nxt  = '0;
            low_nxt   = '0;
            idle_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = SYNC;
                    per_nxt   = '0;
                    high_nxt  = '0;
                    low_nxt   = '0;
                    idle_nxt  = '0;
                end
                SYNC: begin
                    if (rise) begin
                        state_nxt = HIGH;
                        per_nxt   = CW'(1);
                        high_nxt  = CW'(1);
                        low_nxt   = '0;
                    end
                end
                HIGH: begin
                    per_nxt = sat_inc(per_cnt);
                    if (fall) begin
                        state_nxt = LOW;
                        low_nxt   = CW'(1);
                    end else begin
                        high_nxt = sat_inc(high_cnt);
                    end
                end
                LOW: begin
                    if (rise) begin
                        pub       = 1'b1;
                        state_nxt = HIGH;
                        per_nxt   = CW'(1);
                        high_nxt  = CW'(1);
                        low_nxt   = '0;
                    end else begin
                        per_nxt = sat_inc(per_cnt);
                        low_nxt = sat_inc(low_cnt);
                    end
                end
            endcase
            // rise beats an expiring idle counter
            if (state != IDLE) begin
                if (rise || fall) begin
                    idle_nxt = '0;
                    tmo_clr  = rise;
                end else if (idle_cnt == TLAST) begin
                    tmo_fire  = 1'b1;
                    idle_nxt  = '0;
                    state_nxt = SYNC;
                    per_nxt   = '0;
                    high_nxt  = '0;
                    low_nxt   = '0;
                end else begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end
        end
    end

    assign ovf  = per_cnt[CW-1] | high_cnt[CW-1] | low_cnt[CW-1];
    assign mis  = (i_exp_ratio >= ratio_width'(2)) &&
                  (ovf || (per_cnt != {1'b0, i_exp_ratio}));
    assign diff = (high_cnt > low_cnt) ? high_cnt - low_cnt
                                       : low_cnt - high_cnt;
    assign duty = diff > CW'(1);

    always_ff @(posedge i_ref_clk) begin
        if (!i_rst) begin
            state        <= IDLE;
            per_cnt      <= '0;
            high_cnt     <= '0;
            low_cnt      <= '0;
            idle_cnt     <= '0;
            st_valid     <= 1'b0;
            st_mis       <= 1'b0;
            st_duty      <= 1'b0;
            st_meas      <= '0;
            st_high      <= '0;
            st_low       <= '0;
            o_valid      <= 1'b0;
            o_mismatch   <= 1'b0;
            o_duty_err   <= 1'b0;
            o_timeout    <= 1'b0;
            o_meas_ratio <= '0;
            o_high_cnt   <= '0;
            o_low_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            per_cnt  <= per_nxt;
            high_cnt <= high_nxt;
            low_cnt  <= low_nxt;
            idle_cnt <= idle_nxt;
            if (!i_mon_en) begin
                st_valid <= 1'b0;
                o_valid  <= 1'b0;
            end else begin
                // snapshot stage frees the counters to restart immediately
                st_valid <= pub;
                if (pub) begin
                    st_meas <= per_cnt[ratio_width-1:0];
                    st_high <= high_cnt[ratio_width-1:0];
                    st_low  <= low_cnt[ratio_width-1:0];
                    st_mis  <= mis;
                    st_duty <= duty;
                end
                o_valid <= st_valid;
                if (st_valid) begin
                    o_meas_ratio <= st_meas;
                    o_high_cnt   <= st_high;
                    o_low_cnt    <= st_low;
                    o_mismatch   <= st_mis;
                    o_duty_err   <= st_duty;
                end
                if (tmo_fire) begin
                    o_timeout    <= 1'b1;
                    o_meas_ratio <= '0;
                    o_high_cnt   <= '0;
                    o_low_cnt    <= '0;
                end else if (tmo_clr) begin
                    o_timeout <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor: directed and random divided clocks
// compared every cycle against a timestamp-based reference model.
module tb_clk_ratio_monitor;

    localparam int RW  = 8;
    localparam int TMO = 2 ** (RW + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          div = 1'b0;
    logic [RW-1:0] exp_r = '0;
    logic [RW-1:0] meas, high, low;
    logic          valid, mism, duty, tmo;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // stimulus clock generator
    int g_ratio = 1;
    int g_hi = 0;
    int g_ph = 0;

    // reference model state (times in reference cycles)
    bit m_dq1, m_dq2, m_act, m_started, m_pend;
    int m_lr, m_lf, m_le;
    int p_meas, p_high, p_low;
    bit p_mis, p_duty;
    logic [RW-1:0] e_meas, e_high, e_low;
    logic e_valid, e_mis, e_duty, e_tmo;

    clk_ratio_monitor #(.ratio_width(RW)) dut (
        .i_ref_clk    (clk),
        .i_rst        (rst),
        .i_mon_en     (en),
        .i_div_clk    (div),
        .i_exp_ratio  (exp_r),
        .o_meas_ratio (meas),
        .o_high_cnt   (high),
        .o_low_cnt    (low),
        .o_valid      (valid),
        .o_mismatch   (mism),
        .o_duty_err   (duty),
        .o_timeout    (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                   tag, cyc, obs, want);
        end
    endtask

    task automatic model_step();
        bit r, f;
        int d;
        r = m_dq1 & ~m_dq2;
        f = ~m_dq1 & m_dq2;
        e_valid = 1'b0;
        if (!rst) begin
            m_act = 0; m_started = 0; m_pend = 0;
            e_meas = '0; e_high = '0; e_low = '0;
            e_mis = 0; e_duty = 0; e_tmo = 0;
        end else if (!en) begin
            m_act = 0; m_started = 0; m_pend = 0;
        end else begin
            if (m_pend) begin
                e_valid = 1'b1;
                e_meas = RW'(p_meas); e_high = RW'(p_high);
                e_low = RW'(p_low);
                e_mis = p_mis; e_duty = p_duty;
                m_pend = 0;
            end
            if (!m_act) begin
                m_act = 1; m_started = 0; m_le = cyc;
            end else if (r) begin
                e_tmo = 0; m_le = cyc;
                if (m_started) begin
                    p_meas = cyc - m_lr;
                    p_high = m_lf - m_lr;
                    p_low = cyc - m_lf;
                    d = p_high - p_low;
                    p_duty = (d > 1) || (d < -1);
                    p_mis = (exp_r >= 2) &&
                            (p_meas > 255 || p_high > 255 ||
                             p_low > 255 || p_meas != int'(exp_r));
                    m_pend = 1;
                end
                m_started = 1; m_lr = cyc;
            end else if (f) begin
                m_le = cyc; m_lf = cyc;
            end else if (cyc - m_le == TMO) begin
                e_tmo = 1; m_started = 0; m_le = cyc;
                e_meas = '0; e_high = '0; e_low = '0;
            end
        end
        m_dq2 = rst ? m_dq1 : 1'b0;
        m_dq1 = rst ? div : 1'b0;
    endtask

    task automatic compare();
        check("valid", int'(valid), int'(e_valid));
        check("meas", int'(meas), int'(e_meas));
        check("high", int'(high), int'(e_high));
        check("low", int'(low), int'(e_low));
        check("mismatch", int'(mism), int'(e_mis));
        check("duty_err", int'(duty), int'(e_duty));
        check("timeout", int'(tmo), int'(e_tmo));
    endtask

    task automatic tick();
        if (g_ratio < 2) begin
            div = 1'b0;
        end else begin
            div = (g_ph < g_hi);
            g_ph = (g_ph + 1 == g_ratio) ? 0 : g_ph + 1;
        end
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_div(input int r, input int hi, input int e);
        g_ratio = r;
        g_hi = hi;
        g_ph = 0;
        exp_r = RW'(e);
    endtask

    initial begin
        int r, hi, k;
        @(negedge clk);
        rst = 1'b0;
        run(3);
        check("rst_valid", int'(valid), 0);
        check("rst_meas", int'(meas), 0);
        check("rst_timeout", int'(tmo), 0);
        rst = 1'b1;

        en = 1'b1;
        set_div(4, 2, 4);
        run(40);
        check("r4_meas", int'(meas), 4);
        check("r4_high", int'(high), 2);

        set_div(5, 3, 5);
        run(40);
        check("r5_meas", int'(meas), 5);
        check("r5_duty", int'(duty), 0);

        set_div(8, 4, 6);
        run(48);
        check("r8e6_mis", int'(mism), 1);
        check("r8e6_meas", int'(meas), 8);

        set_div(1, 0, 1);
        run(600);
        check("byp_timeout", int'(tmo), 1);
        check("byp_meas", int'(meas), 0);

        set_div(2, 1, 2);
        run(20);
        rst = 1'b0;
        run(2);
        check("rst2_meas", int'(meas), 0);
        check("rst2_timeout", int'(tmo), 0);
        set_div(6, 3, 6);
        rst = 1'b1;
        run(40);
        check("r6_meas", int'(meas), 6);

        set_div(8, 4, 8);
        run(40);
        k = 0;
        while (g_ph != 2 && k < 20) begin
            tick();
            k++;
        end
        check("mid_high_bound", int'(g_ph == 2), 1);
        run(2);
        en = 1'b0;
        run(10);
        check("hold_meas", int'(meas), 8);
        en = 1'b1;
        run(40);

        set_div(300, 150, 44);
        run(700);
        check("ovf_mis", int'(mism), 1);

        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(2, 40);
            hi = $urandom_range(1, r - 1);
            set_div(r, hi, ($urandom_range(0, 1) != 0) ? r
                                                       : $urandom_range(0, 45));
            for (int j = 0; j < 4 * r + 20; j++) begin
                en = ($urandom_range(0, 59) != 0);
                rst = ($urandom_range(0, 199) != 0);
                tick();
            end
            en = 1'b1;
            rst = 1'b1;
            run(3 * r + 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_ratio_monitor.md
Name: clk_ratio_monitor

Overview:
Receive-side checker for the clock_divider output. Samples a divided clock in the i_ref_clk domain and recovers the division ratio (period), high time and low time in reference-clock cycles. Compares the recovered ratio against an expected ratio and flags mismatch, duty-cycle error and loss of clock. Sits beside clock_divider in the system clocking block as a self-check / BIST observer.

Parameters:
ratio_width, 8, width of i_exp_ratio and o_meas_ratio; matches clock_divider ratio_width.
TIMEOUT, 2**(ratio_width+1), ref cycles without a div-clock edge before o_timeout asserts.

Ports:
i_ref_clk  input  1  reference clock; same clock that drives clock_divider.
i_rst  input  1  synchronous active-low reset.
i_mon_en  input  1  monitor enable; 0 = idle, counters cleared.
i_div_clk  input  1  divided clock under observation; generated from i_ref_clk.
i_exp_ratio  input  ratio_width  expected division ratio.
o_meas_ratio  output  ratio_width  last measured period in ref cycles.
o_high_cnt  output  ratio_width  last measured high time in ref cycles.
o_low_cnt  output  ratio_width  last measured low time in ref cycles.
o_valid  output  1  one-cycle pulse when a new measurement is published.
o_mismatch  output  1  registered with o_valid: measured != expected.
o_duty_err  output  1  registered with o_valid: |high - low| > 1.
o_timeout  output  1  level: no div-clock edge for TIMEOUT ref cycles.

Behaviour:
- Reset (i_rst=0 at posedge i_ref_clk): all outputs 0, state IDLE, counters 0, sample regs 0.
- Sampling: i_div_clk registered into div_q, then div_qq; rise = div_q & ~div_qq; fall = ~div_q & div_qq. No synchroniser (source is i_ref_clk-synchronous).
- States: IDLE, SYNC, HIGH, LOW.
  - IDLE: i_mon_en=1 -> SYNC.
  - SYNC: discard partial period; on rise -> HIGH, high_cnt=1, per_cnt=1.
  - HIGH: increment high_cnt and per_cnt each cycle; on fall -> LOW, low_cnt=1.
  - LOW: increment low_cnt and per_cnt; on rise -> publish, then HIGH with high_cnt=1, per_cnt=1 (continuous back-to-back measurement).
- Publish (cycle after the rise detection): o_meas_ratio=per_cnt, o_high_cnt=high_cnt, o_low_cnt=low_cnt, o_valid=1 for exactly one cycle, o_mismatch=(per_cnt != i_exp_ratio) with i_exp_ratio sampled at the rise, o_duty_err per rule above.
- Latency: o_valid asserts 3 ref cycles after the i_div_clk rising edge that closes the period.
- Counters internally ratio_width+1 bits, saturating; published values truncate to ratio_width; if any counter exceeds 2**ratio_width-1 the publish sets o_mismatch=1.
- i_exp_ratio < 2: comparison disabled, o_mismatch=0 on publish (divider bypass/ratio 0/1 are not measurable).
- Timeout: idle counter clears on every rise/fall, increments otherwise while i_mon_en=1 and not IDLE; reaching TIMEOUT sets o_timeout=1, state -> SYNC, o_meas_ratio/o_high_cnt/o_low_cnt=0. o_timeout clears on next rise.
- i_mon_en deassert mid-measurement: next cycle state IDLE, internal counters cleared, o_valid=0, published outputs and o_timeout hold.
- Reset mid-measurement: full reset, no o_valid.
- Simultaneous rise and timeout in same cycle: rise wins, no timeout.

Decomposition:
- Package clk_mon_pkg: state enum (IDLE, SYNC, HIGH, LOW), DEF_RATIO_WIDTH=8, default TIMEOUT constant.
- One sub-module: edge_detect (two-flop sample of i_div_clk, outputs rise/fall pulses, sync active-low reset).

Test Plan:
- clock_divider ratio 4, exp 4, mon_en=1 -> o_valid every 4 cycles after first full period; meas=4, high=2, low=2, mismatch=0, duty_err=0.
- Ratio 5, exp 5 -> meas=5, high+low=5 with |high-low|=1, mismatch=0, duty_err=0.
- Ratio 8, exp 6 -> meas=8, high=4, low=4, o_mismatch=1 on every o_valid.
- Divider ratio 1 (bypass), exp 1 -> no o_valid; o_timeout=1 after 512 cycles (ratio_width=8); outputs 0; mismatch stays 0.
- Ratio 2 running, i_rst=0 for 2 cycles then ratio 6 -> all outputs 0 during reset; first o_valid only after SYNC plus one full period, meas=6.
- i_mon_en dropped mid-HIGH with ratio 8 -> no o_valid, last published values held; re-enable -> next o_valid after a complete 8-cycle period.
